// File: rtl/ram_block_banked.sv
// Byte-lane banked single-port RAM with valid/ready request port, in-order response channel,
// out-of-range error flag and post-reset zero-fill. Define RAM_OUT_REG_EN for a 2-cycle response.
module ram_block_banked #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_we,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    input  logic [DATA_WIDTH/8-1:0] i_req_be,
    input  logic [DATA_WIDTH-1:0]   i_req_wdata,
    output logic                    o_rsp_valid,
    output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
    output logic                    o_rsp_err,
    output logic                    o_init_done
);

    localparam int NB_LANES  = DATA_WIDTH / 8;
    localparam int LANE_BITS = (NB_LANES > 1) ? $clog2(NB_LANES) : 0;
    localparam int IDX_W     = ADDR_WIDTH - LANE_BITS;
    localparam int CNT_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     clr_cnt;

    logic [IDX_W-1:0]     req_idx;
    logic                 req_in_range;
    logic                 accept;

    logic [IDX_W-1:0]     mem_idx;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [NB_LANES-1:0]  mem_we;
    logic                 mem_re;
    logic [DATA_WIDTH-1:0] ram_q;

    logic                 rsp_valid_q;
    logic                 rsp_rd_q;
    logic                 rsp_err_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_s1;

    assign req_idx      = i_req_addr[ADDR_WIDTH-1:LANE_BITS];
    assign req_in_range = (32'(req_idx) < DEPTH);
    assign o_req_ready  = o_init_done;
    assign accept       = i_req_valid & o_req_ready;

    generate
        if (LANE_BITS > 0) begin : g_addr_lsbs
            // Sub-word byte offset carries no meaning for a word-wide access.
            logic unused_addr_lsbs;
            assign unused_addr_lsbs = ^i_req_addr[LANE_BITS-1:0];
        end
    endgenerate

    // Single port: the fill engine and the request port share one address/write path.
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        mem_idx   = req_idx;
        mem_wdata = i_req_wdata;
        mem_we    = '0;
        mem_re    = 1'b0;
        if (state == S_CLEAR) begin
            mem_idx   = IDX_W'(clr_cnt);
            mem_wdata = '0;
            mem_we    = '1;
        end else if (accept && req_in_range) begin
            if (i_req_we) begin
                mem_we = i_req_be;
            end else begin
                mem_re = 1'b1;
            end
        end
    end

    generate
        for (genvar k = 0; k < NB_LANES; k++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_q;

            // NOTE: the array and its read register carry no reset so they map onto block RAM;
            // the zero-fill engine provides the known initial contents instead.
            always_ff @(posedge i_clk) begin
                if (mem_we[k]) begin
                    mem[mem_idx] <= mem_wdata[8*k +: 8];
                end
                if (mem_re) begin
                    rd_q <= mem[mem_idx];
                end
            end

            assign ram_q[8*k +: 8] = rd_q;
        end
    endgenerate

    // NOTE: all sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_CLEAR;
            clr_cnt     <= '0;
            o_init_done <= 1'b0;
        end else begin
            case (state)
                S_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == CNT_W'(DEPTH - 1)) begin
                        state       <= S_RUN;
                        o_init_done <= 1'b1;
                    end
                end
                S_RUN: begin
                    o_init_done <= 1'b1;
                end
                default: begin
                    state       <= S_CLEAR;
                    clr_cnt     <= '0;
                    o_init_done <= 1'b0;
                end
            endcase
        end
    end

    // Response control tracks the RAM read register one-for-one.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rsp_valid_q <= 1'b0;
            rsp_rd_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= accept;
            rsp_rd_q    <= accept & ~i_req_we & req_in_range;
            rsp_err_q   <= accept & ~req_in_range;
        end
    end

    // Writes, errors and idle cycles present zero data; the RAM register may hold stale bytes.
    assign rsp_rdata_s1 = rsp_rd_q ? ram_q : '0;

`ifdef RAM_OUT_REG_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
        end else begin
            o_rsp_valid <= rsp_valid_q;
            o_rsp_rdata <= rsp_rdata_s1;
            o_rsp_err   <= rsp_err_q;
        end
    end
`else
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_s1;
    assign o_rsp_err   = rsp_err_q;
`endif

endmodule

// File: tb/tb_ram_block_banked.sv
// Directed bench for ram_block_banked (DEPTH=1000): reset/fill, byte enables, range errors,
// pipelined reads and mid-flight reset, with a per-cycle expected-response delay line.
module tb_ram_block_banked;

`ifdef RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int DEPTH = 1000;

    typedef struct packed {
        logic        v;
        logic [31:0] d;
        logic        e;
    } rsp_t;

    logic        i_clk;
    logic        i_rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [11:0] i_req_addr;
    logic [3:0]  i_req_be;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic        o_init_done;

    int   n_vec = 0;
    int   n_err = 0;
    rsp_t pipe [LAT];
    rsp_t nxt;
    logic exp_ready;

    ram_block_banked #(
        .DATA_WIDTH (32),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (12)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_we    (i_req_we),
        .i_req_addr  (i_req_addr),
        .i_req_be    (i_req_be),
        .i_req_wdata (i_req_wdata),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_rdata (o_rsp_rdata),
        .o_rsp_err   (o_rsp_err),
        .o_init_done (o_init_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs are compared 1 time unit later against the delay line.
    task automatic step();
        logic rst_now;
        rsp_t e;
        rst_now = i_rst;
        @(posedge i_clk);
        #1;
        if (rst_now) begin
            for (int i = 0; i < LAT; i++) pipe[i] = '0;
        end else begin
            for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = nxt;
        end
        nxt = '0;
        e = pipe[LAT-1];
        check("rsp_valid", 32'(o_rsp_valid), 32'(e.v));
        check("rsp_rdata", o_rsp_rdata, e.d);
        check("rsp_err", 32'(o_rsp_err), 32'(e.e));
        check("req_ready", 32'(o_req_ready), 32'(exp_ready));
        check("init_done", 32'(o_init_done), 32'(exp_ready));
    endtask

    // Present one request for exactly one edge; a response is expected only when ready.
    task automatic req(input logic we, input logic [11:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata, input logic [31:0] exp_d, input logic exp_e);
        i_req_valid = 1'b1;
        i_req_we    = we;
        i_req_addr  = addr;
        i_req_be    = be;
        i_req_wdata = wdata;
        if (exp_ready && !i_rst) nxt = '{v: 1'b1, d: exp_d, e: exp_e};
        step();
        i_req_valid = 1'b0;
        i_req_we    = 1'b0;
        i_req_be    = 4'h0;
    endtask

    task automatic flush();
        repeat (LAT + 1) step();
    endtask

    initial begin
        i_rst       = 1'b1;
        i_req_valid = 1'b0;
        i_req_we    = 1'b0;
        i_req_addr  = '0;
        i_req_be    = '0;
        i_req_wdata = '0;
        nxt         = '0;
        exp_ready   = 1'b0;
        for (int i = 0; i < LAT; i++) pipe[i] = '0;

        // Reset state
        step();
        step();

        // T1: fill takes DEPTH edges; a write presented during fill is ignored
        i_rst = 1'b0;
        repeat (DEPTH - 2) step();
        req(1'b1, 12'h000, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b0);
        exp_ready = 1'b1;
        step();
        req(1'b0, 12'h000, 4'h0, 32'h0, 32'h0000_0000, 1'b0);
        flush();

        // T2: write then read next cycle
        req(1'b1, 12'h000, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0);
        req(1'b0, 12'h000, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);
        flush();

        // T3: partial byte enables over a zeroed word; be=0 write is a responding no-op
        req(1'b1, 12'h004, 4'b0101, 32'h1122_3344, 32'h0, 1'b0);
        req(1'b0, 12'h004, 4'h0, 32'h0, 32'h0022_0044, 1'b0);
        req(1'b1, 12'h000, 4'h0, 32'h5555_5555, 32'h0, 1'b0);
        req(1'b0, 12'h000, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);
        req(1'b1, 12'h004, 4'b1000, 32'h99AA_BBCC, 32'h0, 1'b0);
        req(1'b0, 12'h006, 4'h0, 32'h0, 32'h9922_0044, 1'b0);
        flush();

        // T4: last valid index, then out-of-range read/write
        req(1'b1, 12'hF9C, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0);
        req(1'b0, 12'hFA0, 4'h0, 32'h0, 32'h0, 1'b1);
        req(1'b1, 12'hFA0, 4'hF, 32'h1234_5678, 32'h0, 1'b1);
        req(1'b0, 12'hFFC, 4'h0, 32'h0, 32'h0, 1'b1);
        req(1'b0, 12'hF9C, 4'h0, 32'h0, 32'hCAFE_F00D, 1'b0);
        flush();

        // T5: preload words 2..9, then 10 back-to-back reads
        for (int i = 2; i < 10; i++)
            req(1'b1, 12'(4 * i), 4'hF, {8'hA5, 16'h0, 8'(i)}, 32'h0, 1'b0);
        req(1'b0, 12'h000, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);
        req(1'b0, 12'h004, 4'h0, 32'h0, 32'h9922_0044, 1'b0);
        for (int i = 2; i < 10; i++)
            req(1'b0, 12'(4 * i), 4'h0, 32'h0, {8'hA5, 16'h0, 8'(i)}, 1'b0);
        flush();

        // T6: reset coincident with an accepted read drops the response and re-runs fill
        req(1'b0, 12'h004, 4'h0, 32'h0, 32'h9922_0044, 1'b0);
        i_rst     = 1'b1;
        exp_ready = 1'b0;
        req(1'b0, 12'h000, 4'h0, 32'h0, 32'h0, 1'b0);
        i_rst = 1'b0;
        repeat (DEPTH - 1) step();
        exp_ready = 1'b1;
        step();
        req(1'b0, 12'h000, 4'h0, 32'h0, 32'h0, 1'b0);
        req(1'b0, 12'h004, 4'h0, 32'h0, 32'h0, 1'b0);
        req(1'b0, 12'hF9C, 4'h0, 32'h0, 32'h0, 1'b0);
        flush();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
